// File: rtl/load_sequencer_pkg.sv
// Shared constants for the load sequencer and the commutation block.
//   DEF_CNT_W          : default width of the period counter and thresholds
//   SEL_A/SEL_B/SEL_C  : 2-bit input-phase select codes (11 is never used)
//   ADDR_*             : register-file addresses on wr_addr
package load_sequencer_pkg;

  localparam int DEF_CNT_W = 10;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;

  localparam logic [2:0] ADDR_PERIOD = 3'd0;
  localparam logic [2:0] ADDR_T1_A   = 3'd1;
  localparam logic [2:0] ADDR_T2_A   = 3'd2;
  localparam logic [2:0] ADDR_T1_B   = 3'd3;
  localparam logic [2:0] ADDR_T2_B   = 3'd4;
  localparam logic [2:0] ADDR_T1_C   = 3'd5;
  localparam logic [2:0] ADDR_T2_C   = 3'd6;

endpackage

// File: rtl/load_sequencer_phase_selector.sv
// One output phase of the load sequencer: threshold compare against the
// shared period count, t2 clamp, minimum-dwell counter and registered select.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : high lets the selection follow the request
//   count        : current period count
//   t1, t2       : active thresholds for this phase
//   sel          : registered select code (SEL_A/SEL_B/SEL_C)
module load_sequencer_phase_selector
  import load_sequencer_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MIN_DWELL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] t1,
  input  logic [CNT_W-1:0] t2,
  output logic [1:0]       sel
);

  localparam int DW_W = $clog2(MIN_DWELL + 1);
  localparam logic [DW_W-1:0] DW_LOAD = DW_W'(MIN_DWELL - 1);

  logic [CNT_W-1:0] t2_eff;
  logic [1:0]       req;
  logic [DW_W-1:0]  dw;

  // A t2 below t1 collapses the b segment to nothing.
  always_comb begin
    t2_eff = (t2 < t1) ? t1 : t2;
    if (count < t1) begin
      req = SEL_A;
    end else if (count < t2_eff) begin
      req = SEL_B;
    end else begin
      req = SEL_C;
    end
  end

  // The dwell counter runs even while disabled, so a disable does not
  // extend the hold time of the last selection. Requests that vanish
  // before dw expires are simply never applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= SEL_A;
      dw  <= '0;
    end else if (enable && (dw == '0) && (req != sel)) begin
      sel <= req;
      dw  <= DW_LOAD;
    end else if (dw != '0) begin
      dw <= dw - DW_W'(1);
    end
  end

endmodule

// File: rtl/load_sequencer.sv
// Load sequencer: programmable PWM period counter plus three phase selectors
// producing the 6-bit desired-load word (AABBCC) for the commutation FSMs.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   enable        : run modulation; low forces count to 0 and freezes outputs
//   wr_en         : one-cycle register write strobe
//   wr_addr       : 0 period, 1/2 t1/t2 A, 3/4 t1/t2 B, 5/6 t1/t2 C, 7 ignored
//   wr_data       : value written
//   DesiredLoad   : [5:4] phase A, [3:2] phase B, [1:0] phase C select codes
//   period_start  : one-cycle pulse aligned with the outputs computed at count 0
module load_sequencer
  import load_sequencer_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MIN_DWELL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  output logic [5:0]       DesiredLoad,
  output logic             period_start
);

  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] t1_sh  [3];
  logic [CNT_W-1:0] t2_sh  [3];
  logic [CNT_W-1:0] t1_act [3];
  logic [CNT_W-1:0] t2_act [3];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] p_eff;
  logic             wrap;
  logic [1:0]       sel [3];

  assign p_eff = (period_act < MIN_PERIOD) ? MIN_PERIOD : period_act;
  // ">=" rather than "==" so an out-of-range count always wraps next cycle.
  assign wrap  = enable && (count >= (p_eff - CNT_W'(1)));

  // Shadow registers: MCU-facing, take effect only at a period wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_sh <= '0;
      for (int i = 0; i < 3; i++) begin
        t1_sh[i] <= '0;
        t2_sh[i] <= '0;
      end
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_PERIOD: period_sh <= wr_data;
        ADDR_T1_A:   t1_sh[0]  <= wr_data;
        ADDR_T2_A:   t2_sh[0]  <= wr_data;
        ADDR_T1_B:   t1_sh[1]  <= wr_data;
        ADDR_T2_B:   t2_sh[1]  <= wr_data;
        ADDR_T1_C:   t1_sh[2]  <= wr_data;
        ADDR_T2_C:   t2_sh[2]  <= wr_data;
        default:     ;
      endcase
    end
  end

  // Active registers copy the pre-edge shadow values, so a write landing in
  // the wrap cycle waits for the following wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_act <= '0;
      for (int i = 0; i < 3; i++) begin
        t1_act[i] <= '0;
        t2_act[i] <= '0;
      end
    end else if (wrap) begin
      period_act <= period_sh;
      for (int i = 0; i < 3; i++) begin
        t1_act[i] <= t1_sh[i];
        t2_act[i] <= t2_sh[i];
      end
    end
  end

  // Period counter and start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= enable && (count == '0);
      if (!enable || wrap) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  for (genvar p = 0; p < 3; p++) begin : g_phase
    load_sequencer_phase_selector #(
      .CNT_W     (CNT_W),
      .MIN_DWELL (MIN_DWELL)
    ) u_phase_selector (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .count  (count),
      .t1     (t1_act[p]),
      .t2     (t2_act[p]),
      .sel    (sel[p])
    );
  end

  assign DesiredLoad = {sel[0], sel[1], sel[2]};

endmodule
